// File: rtl/axi_read_arbiter_pkg.sv
// Shared definitions for the two-port AXI read arbiter: FSM encoding and
// requester port indices.
package axi_read_arbiter_pkg;

    // Arbiter FSM: one outstanding transaction, address phase then data phase.
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ADDR = 2'd1,
        ST_DATA = 2'd2
    } arb_state_t;

    // Requester indices into the packed per-port buses.
    localparam logic ICACHE = 1'b0;
    localparam logic DCACHE = 1'b1;

endpackage

// File: rtl/axi_read_arbiter.sv
// Two-port (icache/dcache) AXI read-channel arbiter. Grants one requester at a
// time with round-robin tie-break, forwards the AR request, then routes the R
// beats back to the granted port while checking the beat count against arlen.
module axi_read_arbiter
    import axi_read_arbiter_pkg::*;
#(
    parameter int unsigned ADDR_W = 32,
    parameter int unsigned LEN_W  = 4
) (
    input  logic                  aclk,
    input  logic                  aresetn,
    input  logic [1:0]            s_arvalid,
    input  logic [2*ADDR_W-1:0]   s_araddr,
    input  logic [2*LEN_W-1:0]    s_arlen,
    output logic [1:0]            s_arready,
    output logic [1:0]            s_rvalid,
    output logic [1:0]            s_rlast,
    output logic [31:0]           s_rdata,
    output logic [1:0]            s_busy,
    output logic                  m_arvalid,
    output logic [ADDR_W-1:0]     m_araddr,
    output logic [LEN_W-1:0]      m_arlen,
    input  logic                  m_arready,
    input  logic                  m_rvalid,
    input  logic                  m_rlast,
    input  logic [31:0]           m_rdata,
    output logic                  m_rready,
    output logic                  len_err
);

    arb_state_t          r_state;
    arb_state_t          w_next_state;
    logic                r_last_grant;
    logic                r_grant;
    logic [ADDR_W-1:0]   r_addr;
    logic [LEN_W-1:0]    r_len;
    logic [LEN_W:0]      r_cnt;
    logic                r_len_err;

    logic                w_grant_en;
    logic                w_grant_sel;
    logic                w_beat;
    logic                w_last_beat;
    logic [ADDR_W-1:0]   w_sel_addr;
    logic [LEN_W-1:0]    w_sel_len;

    // Pick the requested address/length of the port being granted.
    always_comb begin
        w_sel_addr = s_araddr[ADDR_W-1:0];
        w_sel_len  = s_arlen[LEN_W-1:0];
        if (w_grant_sel == DCACHE) begin
            w_sel_addr = s_araddr[2*ADDR_W-1:ADDR_W];
            w_sel_len  = s_arlen[2*LEN_W-1:LEN_W];
        end
    end

    // FSM next-state and all routed outputs; outputs held at zero in reset.
    always_comb begin
        w_next_state = r_state;
        w_grant_en   = 1'b0;
        w_grant_sel  = r_last_grant;
        w_beat       = 1'b0;
        w_last_beat  = 1'b0;
        s_arready    = '0;
        s_rvalid     = '0;
        s_rlast      = '0;
        s_rdata      = '0;
        s_busy       = '0;
        m_arvalid    = 1'b0;
        m_rready     = 1'b0;

        case (r_state)
            ST_IDLE: begin
                if (aresetn) begin
                    case (s_arvalid)
                        2'b01: begin
                            w_grant_en  = 1'b1;
                            w_grant_sel = ICACHE;
                        end
                        2'b10: begin
                            w_grant_en  = 1'b1;
                            w_grant_sel = DCACHE;
                        end
                        2'b11: begin
                            w_grant_en  = 1'b1;
                            w_grant_sel = ~r_last_grant;
                        end
                        default: begin
                            w_grant_en  = 1'b0;
                        end
                    endcase
                end
                if (w_grant_en) begin
                    s_arready[w_grant_sel] = 1'b1;
                    w_next_state           = ST_ADDR;
                end
            end

            ST_ADDR: begin
                m_arvalid         = 1'b1;
                s_busy[~r_grant]  = 1'b1;
                if (m_arready) begin
                    w_next_state = ST_DATA;
                end
            end

            ST_DATA: begin
                m_rready           = 1'b1;
                s_busy[~r_grant]   = 1'b1;
                s_rvalid[r_grant]  = m_rvalid;
                s_rlast[r_grant]   = m_rlast;
                s_rdata            = m_rdata;
                w_beat             = m_rvalid;
                w_last_beat        = m_rvalid & m_rlast;
                if (w_last_beat) begin
                    w_next_state = ST_IDLE;
                end
            end

            default: begin
                w_next_state = ST_IDLE;
            end
        endcase
    end

    // FSM state register; reset abandons any transaction in flight.
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Grant bookkeeping and latched AR request.
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            r_last_grant <= ICACHE;
            r_grant      <= ICACHE;
            r_addr       <= '0;
            r_len        <= '0;
        end else if (w_grant_en) begin
            r_last_grant <= w_grant_sel;
            r_grant      <= w_grant_sel;
            r_addr       <= w_sel_addr;
            r_len        <= w_sel_len;
        end
    end

    // Beat counter and sticky length-mismatch flag; the count compared on the
    // last beat is the number of beats before it, which equals arlen when the
    // burst is the requested arlen+1 beats long.
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            r_cnt     <= '0;
            r_len_err <= 1'b0;
        end else begin
            if (w_grant_en) begin
                r_cnt <= '0;
            end else if (w_beat) begin
                r_cnt <= r_cnt + {{LEN_W{1'b0}}, 1'b1};
            end
            if (w_last_beat && (r_cnt != {1'b0, r_len})) begin
                r_len_err <= 1'b1;
            end
        end
    end

    assign m_araddr = r_addr;
    assign m_arlen  = r_len;
    assign len_err  = r_len_err;

endmodule
